// File: rtl/adc_lvds_tx_serializer_14b.sv
// ---------------------------------------------------------------------------------------------
// adc_lvds_tx_serializer_14b
//
// Fabric-side 14:1 DDR serializer that mimics one lane of a 14-bit ADC with AD9252-style
// framing. Parallel words arrive on a valid/ready handshake. Each CLK cycle emits two serial
// bits (D_RISE first, then D_FALL) for an external ODDR, plus the matching frame-clock pair.
// One frame is 7 CLK cycles (14 bits). The frame clock is high for the first 7 bits.
//
// Ports
//   CLK        in   bit-pair clock (one cycle = 2 serial bits)
//   RSTN       in   asynchronous active-low reset
//   S_DATA     in   [13:0] parallel sample word
//   S_VALID    in   S_DATA valid
//   S_READY    out  word can be accepted this cycle (combinational)
//   TEST_MODE  in   [1:0] 0 normal, 1 deskew, 2 sync, 3 inverted sync (sampled at load)
//   D_RISE     out  serial bit for the rising half of the cycle (earlier bit)
//   D_FALL     out  serial bit for the falling half of the cycle (later bit)
//   FCO_RISE   out  frame-clock bit, rising half
//   FCO_FALL   out  frame-clock bit, falling half
//   SOF        out  high while the first bit pair of a frame is on D_RISE/D_FALL
//   UNDERRUN   out  one-cycle pulse when IDLE_WORD was loaded for lack of data
// ---------------------------------------------------------------------------------------------
module adc_lvds_tx_serializer_14b #(
    parameter bit          MSB_FIRST   = 1'b1,
    parameter logic [13:0] IDLE_WORD   = 14'h0000,
    parameter logic [13:0] DESKEW_WORD = 14'h2AAA,
    parameter logic [13:0] SYNC_WORD   = 14'h3F80
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [13:0] S_DATA,
    input  logic        S_VALID,
    output logic        S_READY,
    input  logic [1:0]  TEST_MODE,
    output logic        D_RISE,
    output logic        D_FALL,
    output logic        FCO_RISE,
    output logic        FCO_FALL,
    output logic        SOF,
    output logic        UNDERRUN
);

    localparam logic [2:0] PhLast = 3'd6;

    // Reverse bit order so that bit 0 ends up at the shift-out end of the register.
    function automatic logic [13:0] bit_rev(input logic [13:0] w);
        logic [13:0] r;
        for (int i = 0; i < 14; i++) begin
            r[i] = w[13 - i];
        end
        return r;
    endfunction

    logic [13:0] sr_q, sr_d;
    logic [2:0]  ph_q, ph_d;
    logic [13:0] buf_q, buf_d;
    logic        buf_v_q, buf_v_d;
    logic        fco_rise_q, fco_rise_d;
    logic        fco_fall_q, fco_fall_d;
    logic        sof_q, sof_d;
    logic        underrun_q, underrun_d;

    logic        load;
    logic        s_ready;
    logic        accept;
    logic [13:0] load_word;

    // A load edge is the last pair of the current frame; the next word enters SR on it.
    assign load    = (ph_q == PhLast);
    // The buffer frees up on a load edge, so a word can be taken even while it is full.
    assign s_ready = (TEST_MODE == 2'd0) && (!buf_v_q || load);
    assign accept  = S_VALID && s_ready;

    always_comb begin
        sr_d       = {sr_q[11:0], 2'b00};
        ph_d       = ph_q + 3'd1;
        buf_d      = buf_q;
        buf_v_d    = buf_v_q;
        sof_d      = 1'b0;
        underrun_d = 1'b0;
        load_word  = IDLE_WORD;

        if (load) begin
            ph_d  = 3'd0;
            sof_d = 1'b1;

            if (TEST_MODE != 2'd0) begin
                // Pattern modes leave the buffer alone; S_READY is low so nothing is accepted.
                unique case (TEST_MODE)
                    2'd1:    load_word = DESKEW_WORD;
                    2'd2:    load_word = SYNC_WORD;
                    default: load_word = ~SYNC_WORD;
                endcase
            end else if (buf_v_q) begin
                load_word = buf_q;
                if (accept) begin
                    buf_d = S_DATA;
                end else begin
                    buf_v_d = 1'b0;
                end
            end else if (accept) begin
                // Empty buffer: bypass straight into the shift register.
                load_word = S_DATA;
            end else begin
                load_word  = IDLE_WORD;
                underrun_d = 1'b1;
            end

            sr_d = MSB_FIRST ? load_word : bit_rev(load_word);
        end else if (accept) begin
            buf_d   = S_DATA;
            buf_v_d = 1'b1;
        end

        // Frame clock follows the phase that will be on the outputs after this edge:
        // high for bits 0..6, low for bits 7..13.
        unique case (ph_d)
            3'd0, 3'd1, 3'd2: begin
                fco_rise_d = 1'b1;
                fco_fall_d = 1'b1;
            end
            3'd3: begin
                fco_rise_d = 1'b1;
                fco_fall_d = 1'b0;
            end
            default: begin
                fco_rise_d = 1'b0;
                fco_fall_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sr_q       <= 14'd0;
            ph_q       <= PhLast;
            buf_q      <= 14'd0;
            buf_v_q    <= 1'b0;
            fco_rise_q <= 1'b0;
            fco_fall_q <= 1'b0;
            sof_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            ph_q       <= ph_d;
            buf_q      <= buf_d;
            buf_v_q    <= buf_v_d;
            fco_rise_q <= fco_rise_d;
            fco_fall_q <= fco_fall_d;
            sof_q      <= sof_d;
            underrun_q <= underrun_d;
        end
    end

    assign S_READY  = s_ready;
    assign D_RISE   = sr_q[13];
    assign D_FALL   = sr_q[12];
    assign FCO_RISE = fco_rise_q;
    assign FCO_FALL = fco_fall_q;
    assign SOF      = sof_q;
    assign UNDERRUN = underrun_q;

endmodule

// File: tb/tb_adc_lvds_tx_serializer_14b.sv
module tb_adc_lvds_tx_serializer_14b;

    logic        clk;
    logic        rstn;
    logic [13:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  test_mode;
    logic        d_rise, d_fall, fco_rise, fco_fall, sof, underrun;

    logic        rstn_b;
    logic [13:0] s_data_b;
    logic        s_valid_b;
    logic        s_ready_b;
    logic [1:0]  test_mode_b;
    logic        d_rise_b, d_fall_b, fco_rise_b, fco_fall_b, sof_b, underrun_b;

    int n_cmp;
    int n_err;

    // {D_RISE, D_FALL, FCO_RISE, FCO_FALL, SOF, UNDERRUN}
    logic [5:0] obs_a, obs_b;
    assign obs_a = {d_rise, d_fall, fco_rise, fco_fall, sof, underrun};
    assign obs_b = {d_rise_b, d_fall_b, fco_rise_b, fco_fall_b, sof_b, underrun_b};

    logic [1:0] fco_tab [7];

    adc_lvds_tx_serializer_14b dut_a (
        .CLK       (clk),
        .RSTN      (rstn),
        .S_DATA    (s_data),
        .S_VALID   (s_valid),
        .S_READY   (s_ready),
        .TEST_MODE (test_mode),
        .D_RISE    (d_rise),
        .D_FALL    (d_fall),
        .FCO_RISE  (fco_rise),
        .FCO_FALL  (fco_fall),
        .SOF       (sof),
        .UNDERRUN  (underrun)
    );

    adc_lvds_tx_serializer_14b #(
        .MSB_FIRST (1'b0)
    ) dut_b (
        .CLK       (clk),
        .RSTN      (rstn_b),
        .S_DATA    (s_data_b),
        .S_VALID   (s_valid_b),
        .S_READY   (s_ready_b),
        .TEST_MODE (test_mode_b),
        .D_RISE    (d_rise_b),
        .D_FALL    (d_fall_b),
        .FCO_RISE  (fco_rise_b),
        .FCO_FALL  (fco_fall_b),
        .SOF       (sof_b),
        .UNDERRUN  (underrun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench sampled at PH6 of a frame, so the next edge is a load edge.
    task automatic goto_load();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sof) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL goto_load: SOF never seen, got 0 required 1");
        end
        repeat (6) step();
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        s_valid   = 1'b0;
        s_data    = 14'd0;
        test_mode = 2'd0;
        repeat (5) step();
        n_cmp++;
        if (obs_a !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 000000", obs_a);
        end
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b required 1", s_ready);
        end
        rstn = 1'b1;
        step();
        n_cmp++;
        if (obs_a !== 6'b001111) begin
            n_err++;
            $display("FAIL reset_first_idle: got %b required 001111", obs_a);
        end
        step();
        n_cmp++;
        if (obs_a !== 6'b001100) begin
            n_err++;
            $display("FAIL reset_idle_ph1: got %b required 001100", obs_a);
        end
    endtask

    task automatic test_frame();
        logic [1:0] pairs [7];
        logic [5:0] exp;
        pairs = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00};
        goto_load();
        s_valid = 1'b1;
        s_data  = 14'h3A5C;
        for (int i = 0; i < 7; i++) begin
            step();
            s_valid = 1'b0;
            exp = {pairs[i], fco_tab[i], (i == 0), 1'b0};
            n_cmp++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL frame_3a5c_ph%0d: got %b required %b", i, obs_a, exp);
            end
        end
    endtask

    // Runs straight after test_frame: the next edge is a load with nothing buffered.
    task automatic test_underrun();
        step();
        n_cmp++;
        if (obs_a !== 6'b001111) begin
            n_err++;
            $display("FAIL underrun_load: got %b required 001111", obs_a);
        end
        step();
        n_cmp++;
        if (underrun !== 1'b0) begin
            n_err++;
            $display("FAIL underrun_one_cycle: got %b required 0", underrun);
        end
    endtask

    task automatic test_stream();
        logic [13:0] rx_words [20];
        logic [13:0] rx_sr;
        logic [1:0]  prev_fco;
        int          rx_n, rx_bits, sent;
        bit          acc, und_seen;
        goto_load();
        rx_n     = 0;
        rx_bits  = 0;
        rx_sr    = 14'd0;
        sent     = 0;
        prev_fco = 2'b00;
        und_seen = 1'b0;
        s_valid  = 1'b1;
        s_data   = 14'h1000;
        for (int cyc = 0; cyc < 400 && rx_n < 20; cyc++) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            step();
            if (acc) begin
                sent++;
                if (sent == 20) s_valid = 1'b0;
                else s_data = 14'h1000 + 14'(sent);
            end
            if (underrun) und_seen = 1'b1;
            // Receiver aligns on the frame clock rising edge (00 -> 11), not on SOF.
            if (prev_fco == 2'b00 && {fco_rise, fco_fall} == 2'b11) begin
                rx_sr   = {12'd0, d_rise, d_fall};
                rx_bits = 2;
            end else if (rx_bits > 0) begin
                rx_sr   = {rx_sr[11:0], d_rise, d_fall};
                rx_bits = rx_bits + 2;
            end
            if (rx_bits == 14) begin
                rx_words[rx_n] = rx_sr;
                rx_n++;
                rx_bits = 0;
            end
            prev_fco = {fco_rise, fco_fall};
        end
        s_valid = 1'b0;
        n_cmp++;
        if (rx_n != 20) begin
            n_err++;
            $display("FAIL stream_count: got %0d required 20", rx_n);
        end
        n_cmp++;
        if (und_seen) begin
            n_err++;
            $display("FAIL stream_underrun: got 1 required 0");
        end
        for (int k = 0; k < rx_n; k++) begin
            n_cmp++;
            if (rx_words[k] !== 14'h1000 + 14'(k)) begin
                n_err++;
                $display("FAIL stream_word%0d: got %h required %h", k, rx_words[k],
                         14'h1000 + 14'(k));
            end
        end
    endtask

    task automatic test_modes();
        logic [1:0] sync_pairs [7];
        logic [1:0] inv_pairs  [7];
        logic [5:0] exp;
        sync_pairs = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
        inv_pairs  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11};
        goto_load();
        test_mode = 2'd1;
        #1;
        n_cmp++;
        if (s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL deskew_ready: got %b required 0", s_ready);
        end
        for (int i = 0; i < 7; i++) begin
            step();
            exp = {2'b10, fco_tab[i], (i == 0), 1'b0};
            n_cmp++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL deskew_ph%0d: got %b required %b", i, obs_a, exp);
            end
            if (i == 3) test_mode = 2'd2;
        end
        for (int i = 0; i < 7; i++) begin
            step();
            exp = {sync_pairs[i], fco_tab[i], (i == 0), 1'b0};
            n_cmp++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL sync_ph%0d: got %b required %b", i, obs_a, exp);
            end
            if (i == 6) test_mode = 2'd3;
        end
        for (int i = 0; i < 7; i++) begin
            step();
            exp = {inv_pairs[i], fco_tab[i], (i == 0), 1'b0};
            n_cmp++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL invsync_ph%0d: got %b required %b", i, obs_a, exp);
            end
            if (i == 6) test_mode = 2'd0;
        end
        step();
        n_cmp++;
        if (obs_a !== 6'b001111) begin
            n_err++;
            $display("FAIL mode_back_to_idle: got %b required 001111", obs_a);
        end
    endtask

    task automatic test_lsb_first_reset();
        logic [5:0] exp;
        rstn_b = 1'b1;
        step();
        n_cmp++;
        if (obs_b !== 6'b001111) begin
            n_err++;
            $display("FAIL lsb_first_idle: got %b required 001111", obs_b);
        end
        repeat (6) step();
        s_valid_b = 1'b1;
        s_data_b  = 14'h0001;
        for (int i = 0; i < 5; i++) begin
            step();
            s_valid_b = 1'b0;
            exp = {(i == 0) ? 2'b10 : 2'b00, fco_tab[i], (i == 0), 1'b0};
            n_cmp++;
            if (obs_b !== exp) begin
                n_err++;
                $display("FAIL lsb_first_ph%0d: got %b required %b", i, obs_b, exp);
            end
        end
        // Now at PH4: abort the frame with an asynchronous reset.
        rstn_b = 1'b0;
        #1;
        n_cmp++;
        if (obs_b !== 6'b000000) begin
            n_err++;
            $display("FAIL midframe_reset: got %b required 000000", obs_b);
        end
        n_cmp++;
        if (s_ready_b !== 1'b1) begin
            n_err++;
            $display("FAIL midframe_reset_ready: got %b required 1", s_ready_b);
        end
        step();
        step();
        rstn_b = 1'b1;
        step();
        n_cmp++;
        if (obs_b !== 6'b001111) begin
            n_err++;
            $display("FAIL reset_restart_ph0: got %b required 001111", obs_b);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        fco_tab     = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
        rstn_b      = 1'b0;
        s_valid_b   = 1'b0;
        s_data_b    = 14'd0;
        test_mode_b = 2'd0;
        test_reset();
        test_frame();
        test_underrun();
        test_stream();
        test_modes();
        test_lsb_first_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

endmodule
